// File: rtl/fpga_robots_game_clkseq_if.sv
`default_nettype none
//==============================================================================
// fpga_robots_game_clkseq_if : PLL lock inputs and sequencer outputs
// Rev 1.0
//==============================================================================
interface fpga_robots_game_clkseq_if;
  logic       pll1_locked;
  logic       pll2_locked;
  logic       pll1_rst;
  logic       pll2_rst;
  logic       game_rst_n;
  logic       ready;
  logic [7:0] fail_count;
  logic [2:0] state;

  modport master (
    input  pll1_locked, pll2_locked,
    output pll1_rst, pll2_rst, game_rst_n, ready, fail_count, state
  );

  modport slave (
    output pll1_locked, pll2_locked,
    input  pll1_rst, pll2_rst, game_rst_n, ready, fail_count, state
  );
endinterface
`default_nettype wire

// File: rtl/fpga_robots_game_clkseq.sv
`default_nettype none
//==============================================================================
// fpga_robots_game_clkseq : two-PLL reset/lock sequencer, releases game reset
// Rev 1.0
//==============================================================================
module fpga_robots_game_clkseq #(
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RST_HOLD     = 256,
  parameter int CNT_W        = 17
) (
  input  wire logic                  iclk,
  input  wire logic                  rst_n,
  fpga_robots_game_clkseq_if.master  bus
);

  typedef enum logic [2:0] {
    ST_RST1  = 3'd0,
    ST_WAIT1 = 3'd1,
    ST_RST2  = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_HOLD  = 3'd4,
    ST_RUN   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] C_RST_LAST  = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] C_STAB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] C_TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_stab;
  logic             r_pll1_rst;
  logic             r_pll2_rst;
  logic             r_game_rst_n;
  logic             r_ready;
  logic [7:0]       r_fail;

  logic   w_lk1;
  logic   w_lk2;
  logic   w_watch;
  logic   w_in_wait;
  logic   w_fail;
  state_t w_nxt;

  assign w_lk1     = r_sync1[1];
  assign w_lk2     = r_sync2[1];
  assign w_in_wait = (r_state == ST_WAIT1) || (r_state == ST_WAIT2);

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {r_sync1[0], bus.pll1_locked};
      r_sync2 <= {r_sync2[0], bus.pll2_locked};
    end
  end

  // Lock-1 loss dominates lock-2 loss, which dominates normal phase progress.
  always_comb begin
    w_watch = (r_state == ST_WAIT2) ? w_lk2 : w_lk1;
    w_nxt   = r_state;
    w_fail  = 1'b0;
    if (!w_lk1 && (r_state == ST_RST2 || r_state == ST_WAIT2 ||
                   r_state == ST_HOLD || r_state == ST_RUN)) begin
      w_nxt  = ST_RST1;
      w_fail = 1'b1;
    end else if (!w_lk2 && (r_state == ST_HOLD || r_state == ST_RUN)) begin
      w_nxt  = ST_RST2;
      w_fail = 1'b1;
    end else begin
      case (r_state)
        ST_RST1:  if (r_cnt == C_RST_LAST) w_nxt = ST_WAIT1;
        ST_WAIT1: begin
          if (w_watch && r_stab == C_STAB_LAST) begin
            w_nxt = ST_RST2;
          end else if (r_cnt == C_TMO_LAST) begin
            w_nxt  = ST_RST1;
            w_fail = 1'b1;
          end
        end
        ST_RST2:  if (r_cnt == C_RST_LAST) w_nxt = ST_WAIT2;
        ST_WAIT2: begin
          if (w_watch && r_stab == C_STAB_LAST) begin
            w_nxt = ST_HOLD;
          end else if (r_cnt == C_TMO_LAST) begin
            w_nxt  = ST_RST2;
            w_fail = 1'b1;
          end
        end
        ST_HOLD:  if (r_cnt == C_HOLD_LAST) w_nxt = ST_RUN;
        default:  w_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RST1;
      r_cnt        <= '0;
      r_stab       <= '0;
      r_pll1_rst   <= 1'b1;
      r_pll2_rst   <= 1'b1;
      r_game_rst_n <= 1'b0;
      r_ready      <= 1'b0;
      r_fail       <= 8'd0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state) begin
        r_cnt  <= '0;
        r_stab <= '0;
      end else begin
        // RUN lasts indefinitely, so the phase counter saturates instead of wrapping.
        if (r_cnt != C_CNT_MAX) r_cnt <= r_cnt + 1'b1;
        r_stab <= (w_in_wait && w_watch) ? r_stab + 1'b1 : '0;
      end
      r_pll1_rst   <= (w_nxt == ST_RST1);
      r_pll2_rst   <= (w_nxt == ST_RST1) || (w_nxt == ST_WAIT1) || (w_nxt == ST_RST2);
      r_game_rst_n <= (w_nxt == ST_RUN);
      r_ready      <= (w_nxt == ST_RUN);
      if (w_fail && r_fail != 8'hFF) r_fail <= r_fail + 8'd1;
    end
  end

  assign bus.pll1_rst   = r_pll1_rst;
  assign bus.pll2_rst   = r_pll2_rst;
  assign bus.game_rst_n = r_game_rst_n;
  assign bus.ready      = r_ready;
  assign bus.fail_count = r_fail;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fpga_robots_game_clkseq.sv
`default_nettype none
//==============================================================================
// tb_fpga_robots_game_clkseq : directed bench with a cycle model of the sequencer
// Rev 1.0
//==============================================================================
module tb_fpga_robots_game_clkseq;
  localparam int PRC = 4;
  localparam int LS  = 8;
  localparam int LT  = 32;
  localparam int RH  = 5;

  localparam int M_RST1 = 0, M_WAIT1 = 1, M_RST2 = 2, M_WAIT2 = 3, M_HOLD = 4, M_RUN = 5;

  logic iclk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   ec = 0;

  fpga_robots_game_clkseq_if bus ();

  fpga_robots_game_clkseq #(
    .PLL_RST_CYC (PRC),
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(LT),
    .RST_HOLD    (RH),
    .CNT_W       (17)
  ) u_dut (
    .iclk (iclk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 iclk = ~iclk;

  // Model: time spent in the state, length of the current unbroken lock run, and
  // the two-stage delay of each lock input.
  typedef struct packed {
    int         st;
    int         t;
    int         run;
    int         fails;
    logic [1:0] y1;
    logic [1:0] y2;
  } m_t;

  localparam m_t M_RESET = '{st: M_RST1, t: 0, run: 0, fails: 0, y1: 2'b00, y2: 2'b00};

  function automatic m_t step(m_t m, logic l1, logic l2);
    m_t   n;
    logic k1;
    logic k2;
    int   el;
    int   rn;
    int   dest;
    bit   f;
    n    = m;
    k1   = m.y1[1];
    k2   = m.y2[1];
    n.y1 = {m.y1[0], l1};
    n.y2 = {m.y2[0], l2};
    el   = m.t + 1;
    if (m.st == M_WAIT1)      rn = k1 ? m.run + 1 : 0;
    else if (m.st == M_WAIT2) rn = k2 ? m.run + 1 : 0;
    else                      rn = 0;
    dest = m.st;
    f    = 1'b0;
    if (!k1 && m.st >= M_RST2) begin
      dest = M_RST1; f = 1'b1;
    end else if (!k2 && m.st >= M_HOLD) begin
      dest = M_RST2; f = 1'b1;
    end else if (m.st == M_RST1 || m.st == M_RST2) begin
      if (el == PRC) dest = m.st + 1;
    end else if (m.st == M_WAIT1 || m.st == M_WAIT2) begin
      if (rn == LS) dest = m.st + 1;
      else if (el == LT) begin
        dest = m.st - 1; f = 1'b1;
      end
    end else if (m.st == M_HOLD) begin
      if (el == RH) dest = M_RUN;
    end
    n.st = dest;
    if (dest != m.st) begin
      n.t = 0; n.run = 0;
    end else begin
      n.t = el; n.run = rn;
    end
    if (f && m.fails < 255) n.fails = m.fails + 1;
    return n;
  endfunction

  function automatic logic [14:0] outs_of(m_t m);
    logic [7:0] fc;
    logic [2:0] s;
    fc = m.fails[7:0];
    s  = m.st[2:0];
    return {(m.st == M_RST1), (m.st <= M_RST2), (m.st == M_RUN), (m.st == M_RUN), fc, s};
  endfunction

  m_t m;
  always @(posedge iclk or negedge rst_n) begin
    if (!rst_n) m <= M_RESET;
    else        m <= step(m, bus.pll1_locked, bus.pll2_locked);
  end

  logic [14:0] w_dut;
  assign w_dut = {bus.pll1_rst, bus.pll2_rst, bus.game_rst_n, bus.ready, bus.fail_count, bus.state};

  always begin
    @(posedge iclk);
    #3;
    total++;
    if (w_dut !== outs_of(m)) begin
      bad++;
      $display("FAIL model_cmp t=%0t ec=%0d got=%h expected=%h", $time, ec, w_dut, outs_of(m));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s ec=%0d got=%0d expected=%0d", name, ec, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    ec++;
    #1;
  endtask

  task automatic wait_to(input int n);
    while (ec < n) tick();
  endtask

  task automatic start(input logic l1, input logic l2);
    @(negedge iclk);
    rst_n = 1'b0;
    bus.pll1_locked = l1;
    bus.pll2_locked = l2;
    repeat (3) @(negedge iclk);
    rst_n = 1'b1;
    ec = 0;
  endtask

  initial begin
    bus.pll1_locked = 1'b0;
    bus.pll2_locked = 1'b0;

    // Clean start
    start(1'b1, 1'b1);
    #1;
    chk("rst_pll1_rst", bus.pll1_rst, 1);
    chk("rst_state", bus.state, 0);
    wait_to(3);  chk("t1_pll1_rst_e3", bus.pll1_rst, 1);
    wait_to(4);  chk("t1_pll1_rst_e4", bus.pll1_rst, 0);
                 chk("t1_state_e4", bus.state, 1);
    wait_to(28); chk("t1_ready_e28", bus.ready, 0);
    wait_to(29); chk("t1_ready_e29", bus.ready, 1);
                 chk("t1_game_e29", bus.game_rst_n, 1);
                 chk("t1_fail", bus.fail_count, 0);

    // One-cycle lock1 glitch at stab=5 in WAIT1
    start(1'b1, 1'b1);
    wait_to(7);  @(negedge iclk); bus.pll1_locked = 1'b0;
    wait_to(8);  @(negedge iclk); bus.pll1_locked = 1'b1;
    wait_to(17); chk("t2_state_e17", bus.state, 1);
    wait_to(18); chk("t2_state_e18", bus.state, 2);
                 chk("t2_fail", bus.fail_count, 0);

    // WAIT2 timeouts with lock2 held low
    start(1'b1, 1'b0);
    wait_to(47); chk("t3_state_e47", bus.state, 3);
    wait_to(48); chk("t3_state_e48", bus.state, 2);
                 chk("t3_fail_e48", bus.fail_count, 1);
                 chk("t3_pll1_rst", bus.pll1_rst, 0);
    wait_to(83); chk("t3_state_e83", bus.state, 3);
    wait_to(84); chk("t3_fail_e84", bus.fail_count, 2);

    // Lock2 loss in RUN, then recovery
    start(1'b1, 1'b1);
    wait_to(31); @(negedge iclk); bus.pll2_locked = 1'b0;
    wait_to(33); chk("t4_ready_e33", bus.ready, 1);
    wait_to(34); chk("t4_ready_e34", bus.ready, 0);
                 chk("t4_game_e34", bus.game_rst_n, 0);
                 chk("t4_pll2_rst_e34", bus.pll2_rst, 1);
                 chk("t4_pll1_rst_e34", bus.pll1_rst, 0);
                 chk("t4_fail_e34", bus.fail_count, 1);
    @(negedge iclk); bus.pll2_locked = 1'b1;
    wait_to(37); chk("t4_pll2_rst_e37", bus.pll2_rst, 1);
    wait_to(38); chk("t4_pll2_rst_e38", bus.pll2_rst, 0);
    wait_to(50); chk("t4_ready_e50", bus.ready, 0);
    wait_to(51); chk("t4_ready_e51", bus.ready, 1);

    // Both locks lost together in RUN
    start(1'b1, 1'b1);
    wait_to(31); @(negedge iclk); bus.pll1_locked = 1'b0; bus.pll2_locked = 1'b0;
    wait_to(33); chk("t5_state_e33", bus.state, 5);
    wait_to(34); chk("t5_state_e34", bus.state, 0);
                 chk("t5_fail_e34", bus.fail_count, 1);
    @(negedge iclk); bus.pll1_locked = 1'b1; bus.pll2_locked = 1'b1;
    wait_to(40);

    // Async reset mid-WAIT2, then fail_count saturation
    start(1'b1, 1'b0);
    wait_to(55); chk("t6_state_e55", bus.state, 3);
                 chk("t6_fail_e55", bus.fail_count, 1);
    @(negedge iclk); rst_n = 1'b0;
    #1;
    chk("t6_rst_pll1", bus.pll1_rst, 1);
    chk("t6_rst_pll2", bus.pll2_rst, 1);
    chk("t6_rst_game", bus.game_rst_n, 0);
    chk("t6_rst_ready", bus.ready, 0);
    chk("t6_rst_fail", bus.fail_count, 0);
    chk("t6_rst_state", bus.state, 0);
    start(1'b1, 1'b0);
    wait_to(48 + 36 * 299 + 5);
    chk("t6_fail_sat", bus.fail_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
